cic_comp_fir: RTL and testbench

CIC_COMP_FIR -- requirements
Module: cic_comp_fir

---
 rtl/cic_comp_fir.sv | 115 +++++++++++
 tb/tb_cic_comp_fir.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/cic_comp_fir.sv
// 7-tap CIC droop compensation FIR, one shared multiplier stepping one tap per clock.
// A circular delay line holds the last 7 accepted samples; samples arriving while busy are dropped.
module cic_comp_fir #(
    parameter int NTAPS = 7,
    parameter int IN_W  = 10,
    parameter int OUT_W = 12
) (
    input  logic                    i_clk_high,
    input  logic                    i_reset,
    input  logic signed [IN_W-1:0]  i_signal,
    input  logic                    i_valid,
    output logic signed [OUT_W-1:0] o_signal,
    output logic                    o_valid,
    output logic                    o_busy,
    output logic                    o_overrun
);

    localparam int ACC_W = 17;
    localparam int PTR_W = 3;
    localparam int COEF_W = 8;
    localparam logic [PTR_W-1:0] LAST = PTR_W'(NTAPS - 1);

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_DONE} state_t;

    state_t                  r_state;
    logic signed [IN_W-1:0]  r_dly [NTAPS];
    logic [PTR_W-1:0]        r_wptr;
    logic [PTR_W-1:0]        r_rdptr;
    logic [PTR_W-1:0]        r_tap;
    logic signed [ACC_W-1:0] r_acc;

    logic signed [COEF_W-1:0] w_coef;
    logic signed [IN_W-1:0]   w_samp;
    logic signed [ACC_W-1:0]  w_coef_x;
    logic signed [ACC_W-1:0]  w_samp_x;
    logic signed [ACC_W-1:0]  w_prod;
    logic signed [ACC_W-1:0]  w_sum;

    // c0 weights the newest sample; the set is symmetric and sums to 64.
    function automatic logic signed [COEF_W-1:0] coef(input logic [PTR_W-1:0] k);
        case (k)
            3'd0, 3'd6: coef = -8'sd1;
            3'd1, 3'd5: coef = 8'sd3;
            3'd2, 3'd4: coef = -8'sd10;
            3'd3:       coef = 8'sd80;
            default:    coef = 8'sd0;
        endcase
    endfunction

    // Divide by the DC gain of 64 with +32 bias; the arithmetic shift floors the result.
    function automatic logic signed [OUT_W-1:0] round_out(input logic signed [ACC_W-1:0] s);
        logic signed [ACC_W-1:0] t;
        t = s + $signed(ACC_W'(32));
        t = t >>> 6;
        round_out = t[OUT_W-1:0];
    endfunction

    assign w_coef   = coef(r_tap);
    assign w_samp   = r_dly[r_rdptr];
    assign w_coef_x = {{(ACC_W-COEF_W){w_coef[COEF_W-1]}}, w_coef};
    assign w_samp_x = {{(ACC_W-IN_W){w_samp[IN_W-1]}}, w_samp};
    assign w_prod   = w_coef_x * w_samp_x;
    assign w_sum    = r_acc + w_prod;

    always_ff @(posedge i_clk_high) begin
        if (i_reset) begin
            r_state   <= S_IDLE;
            r_wptr    <= '0;
            r_rdptr   <= '0;
            r_tap     <= '0;
            r_acc     <= '0;
            o_signal  <= '0;
            o_valid   <= 1'b0;
            o_busy    <= 1'b0;
            o_overrun <= 1'b0;
            for (int i = 0; i < NTAPS; i++) r_dly[i] <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_valid) begin
                        r_dly[r_wptr] <= i_signal;
                        r_rdptr       <= r_wptr;
                        r_wptr        <= (r_wptr == LAST) ? '0 : r_wptr + 1'b1;
                        r_acc         <= '0;
                        r_tap         <= '0;
                        o_busy        <= 1'b1;
                        r_state       <= S_MAC;
                    end
                end
                // Walk backwards from the newest sample; the last product goes straight to the output.
                S_MAC: begin
                    if (i_valid) o_overrun <= 1'b1;
                    r_acc   <= w_sum;
                    r_rdptr <= (r_rdptr == '0) ? LAST : r_rdptr - 1'b1;
                    if (r_tap == LAST) begin
                        r_tap    <= '0;
                        o_signal <= round_out(w_sum);
                        o_valid  <= 1'b1;
                        r_state  <= S_DONE;
                    end else begin
                        r_tap <= r_tap + 1'b1;
                    end
                end
                S_DONE: begin
                    if (i_valid) o_overrun <= 1'b1;
                    o_valid <= 1'b0;
                    o_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cic_comp_fir.sv
// Scoreboard bench for cic_comp_fir: a tap-sum reference model predicts each output,
// a negedge monitor checks valid timing, values, busy window and the overrun flag.
module tb_cic_comp_fir;

    logic               clk = 1'b0;
    logic               i_reset = 1'b0;
    logic signed [9:0]  i_signal = '0;
    logic               i_valid = 1'b0;
    logic signed [11:0] o_signal;
    logic               o_valid;
    logic               o_busy;
    logic               o_overrun;

    cic_comp_fir #(.NTAPS(7), .IN_W(10), .OUT_W(12)) dut (
        .i_clk_high (clk),
        .i_reset    (i_reset),
        .i_signal   (i_signal),
        .i_valid    (i_valid),
        .o_signal   (o_signal),
        .o_valid    (o_valid),
        .o_busy     (o_busy),
        .o_overrun  (o_overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {int val; int due;} exp_t;
    exp_t q[$];
    int   obs[$];
    bit   capture = 1'b0;

    int checks = 0;
    int failures = 0;

    int coefs[7] = '{-1, 3, -10, 80, -10, 3, -1};
    int hist[7];
    int last_acc = -1;
    int ovr_cyc = -1;
    int rk_b = -1;
    int rk_o = -1;
    int first_rst = -1;

    task automatic chk(input bit ok, input string name, input int act, input int exp_v);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp_v);
        end
    endtask

    function automatic bit exp_busy(input int c);
        return last_acc >= 0 && c > last_acc && c <= last_acc + 8 &&
               !(rk_b > last_acc && c > rk_b);
    endfunction

    function automatic bit exp_ovr(input int c);
        return ovr_cyc >= 0 && c > ovr_cyc && !(rk_o > ovr_cyc && c > rk_o);
    endfunction

    // Drive one cycle of inputs and update the reference model for it.
    task automatic tick(input bit v, input int s, input bit r);
        int m;
        int sum;
        @(posedge clk);
        #1;
        m = cyc;
        i_valid  = v;
        i_signal = 10'(s);
        i_reset  = r;
        if (r) begin
            if (first_rst < 0) first_rst = m;
            if (rk_b <= last_acc) rk_b = m;
            if (rk_o <= ovr_cyc) rk_o = m;
            for (int k = 0; k < 7; k++) hist[k] = 0;
            while (q.size() > 0 && q[$].due > m) void'(q.pop_back());
        end else if (v) begin
            if (exp_busy(m)) begin
                if (!exp_ovr(m)) ovr_cyc = m;
            end else begin
                for (int k = 6; k > 0; k--) hist[k] = hist[k-1];
                hist[0] = int'(i_signal);
                sum = 0;
                for (int k = 0; k < 7; k++) sum += coefs[k] * hist[k];
                q.push_back('{val: (sum + 32) >>> 6, due: m + 8});
                last_acc = m;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 0, 1'b0);
    endtask

    task automatic strobe_every32(input int s);
        tick(1'b1, s, 1'b0);
        idle(31);
    endtask

    // Monitor: one pass per cycle, away from the active edge.
    int  exp_out = 0;
    bit  rst_prev = 1'b0;
    bit  v_prev = 1'b0;
    always @(negedge clk) begin
        int c;
        c = cyc;
        if (first_rst >= 0 && c > first_rst) begin
            if (rst_prev) exp_out = 0;
            while (q.size() > 0 && q[0].due < c) begin
                chk(1'b0, "missing_valid", 0, q[0].due);
                void'(q.pop_front());
            end
            if (q.size() > 0 && q[0].due == c) begin
                chk(o_valid == 1'b1, "valid_timing", int'(o_valid), 1);
                exp_out = q[0].val;
                void'(q.pop_front());
            end else begin
                chk(o_valid == 1'b0, "spurious_valid", int'(o_valid), 0);
            end
            chk(int'(o_signal) == exp_out, "o_signal", int'(o_signal), exp_out);
            chk(o_busy == exp_busy(c), "o_busy", int'(o_busy), int'(exp_busy(c)));
            chk(o_overrun == exp_ovr(c), "o_overrun", int'(o_overrun), int'(exp_ovr(c)));
            chk(!(v_prev && o_valid), "valid_width", int'(o_valid), 0);
            if (capture && o_valid) obs.push_back(int'(o_signal));
        end
        rst_prev = i_reset;
        v_prev   = o_valid;
    end

    int imp_ref[9] = '{-2, 5, -16, 125, -16, 5, -2, 0, 0};

    task automatic impulse_run(input string name);
        obs.delete();
        capture = 1'b1;
        strobe_every32(100);
        for (int i = 0; i < 10; i++) strobe_every32(0);
        capture = 1'b0;
        chk(obs.size() >= 9, {name, "_count"}, obs.size(), 9);
        for (int i = 0; i < 9 && i < obs.size(); i++)
            chk(obs[i] == imp_ref[i], name, obs[i], imp_ref[i]);
    endtask

    initial begin
        for (int k = 0; k < 7; k++) hist[k] = 0;
        tick(1'b1, 55, 1'b1);
        tick(1'b0, 0, 1'b1);
        tick(1'b0, 0, 1'b1);
        idle(2);
        chk(o_signal == 0 && !o_valid && !o_busy && !o_overrun, "reset_state",
            int'(o_signal), 0);

        impulse_run("impulse");

        for (int i = 0; i < 9; i++) strobe_every32(511);
        chk(int'(o_signal) == 511, "dc_pos", int'(o_signal), 511);
        for (int i = 0; i < 9; i++) strobe_every32(-512);
        chk(int'(o_signal) == -512, "dc_neg", int'(o_signal), -512);

        // Second strobe lands three cycles into the busy window.
        tick(1'b1, 200, 1'b0);
        idle(2);
        tick(1'b1, -300, 1'b0);
        idle(12);
        chk(o_overrun == 1'b1, "overrun_sticky", int'(o_overrun), 1);

        tick(1'b0, 0, 1'b1);
        idle(2);
        tick(1'b1, 400, 1'b0);
        idle(3);
        tick(1'b0, 0, 1'b1);
        idle(12);
        impulse_run("impulse_after_abort");

        tick(1'b1, 123, 1'b0);
        idle(8);
        tick(1'b1, -77, 1'b0);
        idle(7);
        tick(1'b1, 9, 1'b0);
        idle(12);
        chk(o_overrun == 1'b1, "done_cycle_drop", int'(o_overrun), 1);

        tick(1'b0, 0, 1'b1);
        idle(2);
        tick(1'b1, 250, 1'b0);
        idle(8);
        tick(1'b1, -250, 1'b0);
        idle(12);
        chk(o_overrun == 1'b0, "back_to_back_no_overrun", int'(o_overrun), 0);

        for (int i = 0; i < 1500; i++) begin
            bit r;
            r = ($urandom_range(0, 199) == 0);
            tick($urandom_range(0, 5) == 0, int'($urandom_range(0, 1023)) - 512, r);
        end
        idle(15);
        chk(q.size() == 0, "drain", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
